// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file with W bypass, control decode, branch resolution with
// M-stage forwarding, load-use/branch hazard stalls and the D/E pipeline register.
// Optional stall-cycle counter enabled by defining DECODE_STALL_CNT_EN.
module decode_issue_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR   = 5
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [31:0]             InstrD,
    input  logic [DATA_WIDTH-1:0]   PCPlus4D,
    input  logic                    RegWriteW,
    input  logic [REG_ADDR-1:0]     WriteRegW,
    input  logic [DATA_WIDTH-1:0]   ResultW,
    input  logic                    RegWriteM,
    input  logic                    MemtoRegM,
    input  logic [REG_ADDR-1:0]     WriteRegM,
    input  logic [DATA_WIDTH-1:0]   ALUOutM,
    output logic                    StallF,
    output logic                    StallD,
    output logic [1:0]              PCSrcD,
    output logic [DATA_WIDTH-1:0]   PCBranchD,
    output logic [DATA_WIDTH-1:0]   PCJumpD,
    output logic [7:0]              CtrlE,
    output logic [DATA_WIDTH-1:0]   RD1E,
    output logic [DATA_WIDTH-1:0]   RD2E,
    output logic [DATA_WIDTH-1:0]   SignImmE,
    output logic [3*REG_ADDR-1:0]   RegsE,
    output logic [31:0]             StallCount
);

    localparam int NUM_REGS = 2 ** REG_ADDR;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Instruction fields
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [REG_ADDR-1:0] rs_d;
    logic [REG_ADDR-1:0] rt_d;
    logic [REG_ADDR-1:0] rd_d;

    assign opcode = InstrD[31:26];
    assign funct  = InstrD[5:0];
    assign rs_d   = REG_ADDR'(InstrD[25:21]);
    assign rt_d   = REG_ADDR'(InstrD[20:16]);
    assign rd_d   = REG_ADDR'(InstrD[15:11]);

    // Register file
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rf_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rf_d;
    logic [DATA_WIDTH-1:0]               rd1;
    logic [DATA_WIDTH-1:0]               rd2;

    always_comb begin
        rf_d = rf_q;
        if (RegWriteW && (WriteRegW != '0)) begin
            rf_d[WriteRegW] = ResultW;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rf_q <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    // Writes from W are visible to the instruction decoding in the same cycle.
    always_comb begin
        rd1 = rf_q[rs_d];
        rd2 = rf_q[rt_d];
        if (RegWriteW && (WriteRegW != '0) && (WriteRegW == rs_d)) begin
            rd1 = ResultW;
        end
        if (RegWriteW && (WriteRegW != '0) && (WriteRegW == rt_d)) begin
            rd2 = ResultW;
        end
    end

    // Control decode
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       jump;

    always_comb begin
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_ctrl   = 3'b000;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: begin
                        alu_ctrl  = ALU_ADD;
                        reg_write = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                alu_src    = 1'b1;
                alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctrl  = ALU_ADD;
            end
            OP_BEQ: begin
                branch   = 1'b1;
                alu_ctrl = ALU_SUB;
            end
            OP_ADDI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctrl  = ALU_ADD;
            end
            OP_J: begin
                jump = 1'b1;
            end
            default: ;
        endcase
    end

    // Branch/jump targets and branch resolution
    logic [DATA_WIDTH-1:0] sign_imm;
    logic [DATA_WIDTH-1:0] br_a;
    logic [DATA_WIDTH-1:0] br_b;
    logic                  br_eq;

    assign sign_imm  = {{(DATA_WIDTH-16){InstrD[15]}}, InstrD[15:0]};
    assign PCBranchD = PCPlus4D + (sign_imm << 2);
    assign PCJumpD   = {PCPlus4D[DATA_WIDTH-1:28], InstrD[25:0], 2'b00};

    always_comb begin
        br_a = rd1;
        br_b = rd2;
        if (RegWriteM && (WriteRegM != '0) && (WriteRegM == rs_d)) begin
            br_a = ALUOutM;
        end
        if (RegWriteM && (WriteRegM != '0) && (WriteRegM == rt_d)) begin
            br_b = ALUOutM;
        end
    end

    assign br_eq = (br_a == br_b);

    // D/E pipeline register
    logic [7:0]            ctrl_e_q,  ctrl_e_d;
    logic [DATA_WIDTH-1:0] rd1_e_q,   rd1_e_d;
    logic [DATA_WIDTH-1:0] rd2_e_q,   rd2_e_d;
    logic [DATA_WIDTH-1:0] imm_e_q,   imm_e_d;
    logic [3*REG_ADDR-1:0] regs_e_q,  regs_e_d;

    // Hazard detection against the instruction currently in E and the one in M
    logic                mem_to_reg_e;
    logic                reg_write_e;
    logic                reg_dst_e;
    logic [REG_ADDR-1:0] rt_e;
    logic [REG_ADDR-1:0] rd_e;
    logic [REG_ADDR-1:0] write_reg_e;
    logic                lw_stall;
    logic                e_conflict;
    logic                m_conflict;
    logic                branch_stall;
    logic                stall;

    assign reg_write_e  = ctrl_e_q[7];
    assign mem_to_reg_e = ctrl_e_q[6];
    assign reg_dst_e    = ctrl_e_q[0];
    assign rt_e         = regs_e_q[REG_ADDR +: REG_ADDR];
    assign rd_e         = regs_e_q[0 +: REG_ADDR];
    assign write_reg_e  = reg_dst_e ? rd_e : rt_e;

    assign lw_stall   = mem_to_reg_e && ((rt_e == rs_d) || (rt_e == rt_d));
    assign e_conflict = reg_write_e && (write_reg_e != '0)
                        && ((write_reg_e == rs_d) || (write_reg_e == rt_d));
    assign m_conflict = MemtoRegM && (WriteRegM != '0)
                        && ((WriteRegM == rs_d) || (WriteRegM == rt_d));
    assign branch_stall = branch && (e_conflict || m_conflict);
    assign stall        = lw_stall || branch_stall;

    assign StallF = stall;
    assign StallD = stall;
    assign PCSrcD = stall ? 2'b00 : {jump, branch && br_eq};

    // A stalled decode issues a bubble; the held instruction reissues next cycle.
    always_comb begin
        ctrl_e_d = '0;
        rd1_e_d  = '0;
        rd2_e_d  = '0;
        imm_e_d  = '0;
        regs_e_d = '0;
        if (!stall) begin
            ctrl_e_d = {reg_write, mem_to_reg, mem_write, alu_ctrl, alu_src, reg_dst};
            rd1_e_d  = rd1;
            rd2_e_d  = rd2;
            imm_e_d  = sign_imm;
            regs_e_d = {rs_d, rt_d, rd_d};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_e_q <= '0;
            rd1_e_q  <= '0;
            rd2_e_q  <= '0;
            imm_e_q  <= '0;
            regs_e_q <= '0;
        end else begin
            ctrl_e_q <= ctrl_e_d;
            rd1_e_q  <= rd1_e_d;
            rd2_e_q  <= rd2_e_d;
            imm_e_q  <= imm_e_d;
            regs_e_q <= regs_e_d;
        end
    end

    assign CtrlE    = ctrl_e_q;
    assign RD1E     = rd1_e_q;
    assign RD2E     = rd2_e_q;
    assign SignImmE = imm_e_q;
    assign RegsE    = regs_e_q;

`ifdef DECODE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`else
    assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed testbench for decode_issue_stage: decode, bypass, hazards, branch/jump, reset.
module tb_decode_issue_stage;

    localparam int DW = 32;
    localparam int RA = 5;
`ifdef DECODE_STALL_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    localparam logic [31:0] IDLE = 32'hFC00_0000;
    localparam logic [5:0]  FN_ADD = 6'h20;
    localparam logic [5:0]  FN_SUB = 6'h22;
    localparam logic [5:0]  FN_SLT = 6'h2A;

    logic            CLK;
    logic            RST;
    logic [31:0]     InstrD;
    logic [DW-1:0]   PCPlus4D;
    logic            RegWriteW;
    logic [RA-1:0]   WriteRegW;
    logic [DW-1:0]   ResultW;
    logic            RegWriteM;
    logic            MemtoRegM;
    logic [RA-1:0]   WriteRegM;
    logic [DW-1:0]   ALUOutM;
    logic            StallF;
    logic            StallD;
    logic [1:0]      PCSrcD;
    logic [DW-1:0]   PCBranchD;
    logic [DW-1:0]   PCJumpD;
    logic [7:0]      CtrlE;
    logic [DW-1:0]   RD1E;
    logic [DW-1:0]   RD2E;
    logic [DW-1:0]   SignImmE;
    logic [3*RA-1:0] RegsE;
    logic [31:0]     StallCount;

    int errors = 0;
    int checks = 0;

    decode_issue_stage #(.DATA_WIDTH(DW), .REG_ADDR(RA)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .RegWriteW  (RegWriteW),
        .WriteRegW  (WriteRegW),
        .ResultW    (ResultW),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .WriteRegM  (WriteRegM),
        .ALUOutM    (ALUOutM),
        .StallF     (StallF),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .PCJumpD    (PCJumpD),
        .CtrlE      (CtrlE),
        .RD1E       (RD1E),
        .RD2E       (RD2E),
        .SignImmE   (SignImmE),
        .RegsE      (RegsE),
        .StallCount (StallCount)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wreg(input logic [RA-1:0] a, input logic [DW-1:0] v);
        RegWriteW = 1'b1;
        WriteRegW = a;
        ResultW   = v;
        tick();
        RegWriteW = 1'b0;
        WriteRegW = '0;
        ResultW   = '0;
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'b000000, rs[4:0], rt[4:0], rd[4:0], 5'b00000, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, rs[4:0], rt[4:0], imm};
    endfunction

    initial begin
        RST = 1'b1;
        InstrD = IDLE;
        PCPlus4D = '0;
        RegWriteW = 1'b0;
        WriteRegW = '0;
        ResultW = '0;
        RegWriteM = 1'b0;
        MemtoRegM = 1'b0;
        WriteRegM = '0;
        ALUOutM = '0;
        tick();
        tick();
        check("rst_ctrl", CtrlE, 0);
        check("rst_rd1", RD1E, 0);
        check("rst_rd2", RD2E, 0);
        check("rst_imm", SignImmE, 0);
        check("rst_regs", RegsE, 0);
        check("rst_cnt", StallCount, 0);
        check("rst_stall", StallD, 0);
        RST = 1'b0;

        wreg(5'd1, 32'd7);
        wreg(5'd2, 32'd7);
        wreg(5'd5, 32'h11);

        // add R3,R5,R5
        InstrD = r_ins(5, 5, 3, FN_ADD);
        #1;
        check("add_nostall", StallD, 0);
        tick();
        check("add_rd1", RD1E, 32'h11);
        check("add_rd2", RD2E, 32'h11);
        check("add_ctrl", CtrlE, 8'h89);
        check("add_regs", RegsE, 15'h14A3);
        check("add_imm", SignImmE, 32'h1820);

        // add R6,R7,R5 with R7 written by W in the same cycle
        InstrD = r_ins(7, 5, 6, FN_ADD);
        RegWriteW = 1'b1;
        WriteRegW = 5'd7;
        ResultW = 32'h22;
        tick();
        RegWriteW = 1'b0;
        check("bypass_rd1", RD1E, 32'h22);
        check("bypass_rd2", RD2E, 32'h11);

        InstrD = r_ins(1, 2, 3, FN_SUB);
        tick();
        check("sub_ctrl", CtrlE, 8'h99);
        InstrD = r_ins(1, 2, 3, FN_SLT);
        tick();
        check("slt_ctrl", CtrlE, 8'h9D);
        InstrD = r_ins(1, 2, 3, 6'h21);
        tick();
        check("badfn_ctrl", CtrlE, 8'h09);

        InstrD = i_ins(6'h2B, 1, 5, 16'hFFFC);
        tick();
        check("sw_ctrl", CtrlE, 8'h2A);
        check("sw_imm", SignImmE, 32'hFFFF_FFFC);
        InstrD = i_ins(6'h08, 1, 6, 16'h8000);
        tick();
        check("addi_ctrl", CtrlE, 8'h8A);
        check("addi_imm", SignImmE, 32'hFFFF_8000);
        check("addi_regs", RegsE, 15'h04D0);

        // load-use: lw R2,0(R1) then add R4,R2,R1
        InstrD = i_ins(6'h23, 1, 2, 16'h0);
        tick();
        check("lw_ctrl", CtrlE, 8'hCA);
        InstrD = r_ins(2, 1, 4, FN_ADD);
        #1;
        check("lu_stalld", StallD, 1);
        check("lu_stallf", StallF, 1);
        check("lu_pcsrc", PCSrcD, 0);
        tick();
        check("lu_bubble", CtrlE, 0);
        check("lu_bubble_regs", RegsE, 0);
        check("lu_release", StallD, 0);
        tick();
        check("lu_issue_ctrl", CtrlE, 8'h89);
        check("lu_issue_regs", RegsE, 15'h0824);
        check("lu_issue_rd1", RD1E, 32'd7);

        // beq R1,R2 taken
        InstrD = i_ins(6'h04, 1, 2, 16'd4);
        PCPlus4D = 32'h100;
        #1;
        check("beq_pcsrc", PCSrcD, 2'b01);
        check("beq_target", PCBranchD, 32'h110);
        check("beq_nostall", StallD, 0);
        tick();
        check("beq_ctrl", CtrlE, 8'h18);

        // beq R1,R5 not taken, negative offset
        InstrD = i_ins(6'h04, 1, 5, 16'hFFFF);
        #1;
        check("bne_pcsrc", PCSrcD, 2'b00);
        check("bneg_target", PCBranchD, 32'hFC);
        tick();

        InstrD = IDLE;
        wreg(5'd2, 32'd9);

        // beq R1,R2 with R1 forwarded from M
        InstrD = i_ins(6'h04, 1, 2, 16'd4);
        RegWriteM = 1'b1;
        WriteRegM = 5'd1;
        ALUOutM = 32'd9;
        #1;
        check("fwd_pcsrc", PCSrcD, 2'b01);
        check("fwd_nostall", StallD, 0);
        MemtoRegM = 1'b1;
        #1;
        check("mload_stall", StallD, 1);
        check("mload_pcsrc", PCSrcD, 2'b00);
        tick();
        MemtoRegM = 1'b0;
        RegWriteM = 1'b0;
        WriteRegM = '0;
        ALUOutM = '0;
        check("mload_bubble", CtrlE, 0);

        // producer in E: add R1,R5,R5 then beq R1,R2
        InstrD = r_ins(5, 5, 1, FN_ADD);
        tick();
        InstrD = i_ins(6'h04, 1, 2, 16'd4);
        #1;
        check("estage_stall", StallD, 1);
        tick();
        check("estage_bubble", CtrlE, 0);
        check("estage_release", StallD, 0);
        check("estage_pcsrc", PCSrcD, 2'b00);
        check("stall_count", StallCount, CntEn ? 32'd3 : 32'd0);

        // a write to R0 in E never creates a branch hazard
        InstrD = r_ins(5, 5, 0, FN_ADD);
        tick();
        InstrD = i_ins(6'h04, 0, 0, 16'd0);
        PCPlus4D = 32'h200;
        #1;
        check("r0_nostall", StallD, 0);
        check("r0_pcsrc", PCSrcD, 2'b01);
        check("r0_target", PCBranchD, 32'h200);
        tick();

        // j 0x40
        InstrD = {6'b000010, 26'h40};
        PCPlus4D = 32'h1000_0004;
        #1;
        check("j_pcsrc", PCSrcD, 2'b10);
        check("j_target", PCJumpD, 32'h1000_0100);
        tick();
        check("j_ctrl", CtrlE, 0);

        // write to R0 is ignored, including the bypass
        InstrD = r_ins(0, 0, 3, FN_ADD);
        RegWriteW = 1'b1;
        WriteRegW = 5'd0;
        ResultW = 32'hDEAD_BEEF;
        tick();
        RegWriteW = 1'b0;
        ResultW = '0;
        check("r0_bypass_rd1", RD1E, 0);
        check("r0_bypass_rd2", RD2E, 0);
        tick();
        check("r0_stored_rd1", RD1E, 0);

        // reset while a load-use stall is pending
        InstrD = i_ins(6'h23, 1, 2, 16'h0);
        tick();
        InstrD = r_ins(2, 1, 4, FN_ADD);
        #1;
        check("pre_rst_stall", StallD, 1);
        RST = 1'b1;
        tick();
        check("mid_rst_ctrl", CtrlE, 0);
        check("mid_rst_rd1", RD1E, 0);
        check("mid_rst_rd2", RD2E, 0);
        check("mid_rst_imm", SignImmE, 0);
        check("mid_rst_regs", RegsE, 0);
        check("mid_rst_cnt", StallCount, 0);
        check("mid_rst_release", StallD, 0);
        RST = 1'b0;
        InstrD = r_ins(5, 5, 3, FN_ADD);
        tick();
        check("post_rst_rd1", RD1E, 0);
        check("post_rst_ctrl", CtrlE, 8'h89);
        check("post_rst_cnt", StallCount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath/register width (>= 32).
REQ-002 SHALL have parameter REG_ADDR, default 5, register address width; register file depth 2^REG_ADDR.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports named CLK and RST.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 InstrD  input  32  instruction from the IF/D register.
REQ-007 PCPlus4D  input  DATA_WIDTH  PC+4 of InstrD.
REQ-008 RegWriteW / WriteRegW / ResultW  input  1 / REG_ADDR / DATA_WIDTH  writeback port (three separate ports).
REQ-009 RegWriteM / MemtoRegM / WriteRegM  input  1 / 1 / REG_ADDR  memory-stage hazard info (three ports).
REQ-010 ALUOutM  input  DATA_WIDTH  memory-stage ALU result for branch forwarding.
REQ-011 StallF, StallD  output  1 each  hold PC and IF/D register.
REQ-012 PCSrcD  output  2  {jump, branch taken}.
REQ-013 PCBranchD / PCJumpD  output  DATA_WIDTH each  branch and jump targets.
REQ-014 CtrlE  output  8  registered {RegWrite, MemtoReg, MemWrite, ALUControl[2:0], ALUSrc, RegDst}.
REQ-015 RD1E, RD2E, SignImmE  output  DATA_WIDTH each  registered operands and sign-extended immediate.
REQ-016 RegsE  output  3*REG_ADDR  registered {Rs, Rt, Rd}.
REQ-017 StallCount  output  32  stall-cycle counter (see Configuration).

Function
REQ-018 Register file SHALL write ResultW to WriteRegW on CLK when RegWriteW=1; register 0 reads 0 and ignores writes.
REQ-019 Reads SHALL be combinational with same-cycle W bypass: RegWriteW=1, WriteRegW=addr!=0 -> read returns ResultW.
REQ-020 Decode: opcode 000000 R-type (RegWrite, RegDst); 100011 lw (RegWrite, MemtoReg, ALUSrc, add); 101011 sw (MemWrite, ALUSrc, add); 000100 beq (Branch, sub); 001000 addi (RegWrite, ALUSrc, add); 000010 j (Jump); any other opcode -> all controls 0.
REQ-021 R-type funct: 100000 add=010, 100010 sub=110, 100100 and=000, 100101 or=001, 101010 slt=111; other funct -> ALUControl 010, RegWrite 0.
REQ-022 Branch operand A/B SHALL be ALUOutM when RegWriteM=1 and WriteRegM equals Rs/Rt (nonzero), else register-file read.
REQ-023 PCBranchD = PCPlus4D + (SignImm<<2), modulo 2^DATA_WIDTH; PCJumpD = {PCPlus4D[DATA_WIDTH-1:28], InstrD[25:0], 00}.
REQ-024 lwstall = MemtoRegE (registered) and RtE equals RsD or RtD.
REQ-025 branchstall = BranchD and ((RegWriteE and WriteRegE in {RsD,RtD}) or (MemtoRegM and WriteRegM in {RsD,RtD})); WriteRegE = RegDstE ? RdE : RtE; register 0 never matches.
REQ-026 StallF = StallD = lwstall or branchstall, combinational.
REQ-027 PCSrcD = {Jump, Branch and operands equal}, forced 00 while StallD=1.
REQ-028 D/E register SHALL capture decoded fields each CLK (latency 1); when StallD=1, it SHALL load a bubble (all outputs 0) so the held instruction reissues next cycle.

Reset
REQ-029 RST=1 at CLK edge SHALL clear CtrlE, RD1E, RD2E, SignImmE, RegsE, all registers and StallCount to 0; RST overrides a simultaneous write or stall.
REQ-030 Combinational outputs SHALL follow inputs and cleared state during reset; reset mid-stall releases the stall on the following cycle.

Configuration
REQ-031 Macro DECODE_STALL_CNT_EN defined: StallCount increments each CLK with StallD=1, saturating at 0xFFFFFFFF.
REQ-032 Macro undefined: StallCount tied to 0, no counter flops; all other behaviour identical.

Verification
REQ-033 Write R5=0x11 via W, then add R3,R5,R5 -> next cycle RD1E=RD2E=0x11, CtrlE ALUControl=010, RegWrite=1.
REQ-034 lw R2 then add R4,R2,R1 back-to-back -> StallD=1 one cycle, CtrlE bubble 0x00, add issues next cycle.
REQ-035 beq R1,R2 (both 7), PCPlus4D=0x100, imm=4 -> PCSrcD=01, PCBranchD=0x110.
REQ-036 beq with WriteRegM=R1, RegWriteM=1, ALUOutM=9, R2=9 -> forwarded, taken; MemtoRegM=1 instead -> StallD=1, PCSrcD=00.
REQ-037 j 0x0000040, PCPlus4D=0x10000004 -> PCSrcD=10, PCJumpD=0x10000100; write to R0 -> reads stay 0.
REQ-038 RST asserted during a stall -> all registered outputs 0 next cycle; with DECODE_STALL_CNT_EN, 3 stall cycles -> StallCount=3.
